// File: rtl/gate_mux_tester_if.sv
// rtl/gate_mux_tester_if.sv - run handshake and gate stimulus/response bundle for gate_mux_tester
interface gate_mux_tester_if;
   logic start;
   logic abort;
   logic busy;
   logic done;
   logic a_out;
   logic b_out;
   logic and_in;
   logic or_in;
   logic not_in;

   // Environment side: requests runs and returns the gate block's responses.
   modport master (
      output start, abort, and_in, or_in, not_in,
      input  busy, done, a_out, b_out
   );

   // Tester side: accepts run requests and drives the gate block's inputs.
   modport slave (
      input  start, abort, and_in, or_in, not_in,
      output busy, done, a_out, b_out
   );
endinterface

// File: rtl/gate_mux_tester.sv
// rtl/gate_mux_tester.sv - exhaustive 2-input AND/OR/NOT gate block tester
module gate_mux_tester #(
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   gate_mux_tester_if.slave     bus,
   output logic                 pass,
   output logic [2:0]           err_mask,
   output logic [3:0]           and_tbl,
   output logic [3:0]           or_tbl,
   output logic [3:0]           not_tbl,
   output logic [7:0]           run_cnt
);

   generate
      if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
         $error("gate_mux_tester: SETTLE must be in 1..15");
      end
   endgenerate

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

   state_t     state, state_nxt;
   logic [1:0] idx, idx_nxt;
   logic [3:0] settle_cnt, settle_nxt;
   logic       a_r, a_nxt;
   logic       b_r, b_nxt;
   logic       pass_nxt;
   logic [2:0] err_nxt;
   logic [3:0] and_nxt, or_nxt, not_nxt;
   logic [7:0] run_cnt_nxt;
   logic [2:0] err_calc;

   // Reference truth tables indexed by {a,b}: AND=1000, OR=1110, NOT(a)=0011.
   assign err_calc = {not_tbl != 4'b0011, or_tbl != 4'b1110, and_tbl != 4'b1000};

   assign bus.busy  = (state == DRIVE) || (state == CHECK);
   assign bus.done  = (state == DONE);
   assign bus.a_out = a_r;
   assign bus.b_out = b_r;

   // Next-state and next-register computation; abort always beats start and capture.
   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      settle_nxt  = settle_cnt;
      pass_nxt    = pass;
      err_nxt     = err_mask;
      and_nxt     = and_tbl;
      or_nxt      = or_tbl;
      not_nxt     = not_tbl;
      run_cnt_nxt = run_cnt;
      a_nxt       = 1'b0;
      b_nxt       = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_nxt  = DRIVE;
               idx_nxt    = 2'd0;
               settle_nxt = 4'd0;
               and_nxt    = 4'd0;
               or_nxt     = 4'd0;
               not_nxt    = 4'd0;
            end
         end
         DRIVE: begin
            if (bus.abort) begin
               state_nxt = IDLE;
            end else if (settle_cnt == SETTLE_LAST) begin
               and_nxt[idx] = bus.and_in;
               or_nxt[idx]  = bus.or_in;
               not_nxt[idx] = bus.not_in;
               settle_nxt   = 4'd0;
               if (idx == 2'd3) begin
                  state_nxt = CHECK;
               end else begin
                  idx_nxt = idx + 2'd1;
               end
            end else begin
               settle_nxt = settle_cnt + 4'd1;
            end
         end
         CHECK: begin
            if (bus.abort) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = DONE;
               err_nxt   = err_calc;
               pass_nxt  = (err_calc == 3'b000);
               if (err_calc == 3'b000 && run_cnt != 8'hFF) begin
                  run_cnt_nxt = run_cnt + 8'd1;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Stimulus is registered from the upcoming index so it is stable for the whole DRIVE slot.
      if (state_nxt == DRIVE) begin
         a_nxt = idx_nxt[1];
         b_nxt = idx_nxt[0];
      end
   end

   // State and result registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= 2'd0;
         settle_cnt <= 4'd0;
         a_r        <= 1'b0;
         b_r        <= 1'b0;
         pass       <= 1'b0;
         err_mask   <= 3'b000;
         and_tbl    <= 4'd0;
         or_tbl     <= 4'd0;
         not_tbl    <= 4'd0;
         run_cnt    <= 8'd0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         settle_cnt <= settle_nxt;
         a_r        <= a_nxt;
         b_r        <= b_nxt;
         pass       <= pass_nxt;
         err_mask   <= err_nxt;
         and_tbl    <= and_nxt;
         or_tbl     <= or_nxt;
         not_tbl    <= not_nxt;
         run_cnt    <= run_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_gate_mux_tester.sv
// tb/tb_gate_mux_tester.sv - directed self-checking bench for gate_mux_tester
module tb_gate_mux_tester;
   logic clk;
   logic rst_n;
   logic stuck_and;

   int checks;
   int errors;

   gate_mux_tester_if bus1 ();
   gate_mux_tester_if bus3 ();

   logic       p1, p3;
   logic [2:0] e1, e3;
   logic [3:0] at1, ot1, nt1, at3, ot3, nt3;
   logic [7:0] rc1, rc3;

   // Behavioural gate blocks; dut1's AND output can be forced stuck-at-1.
   assign bus1.and_in = stuck_and ? 1'b1 : (bus1.a_out & bus1.b_out);
   assign bus1.or_in  = bus1.a_out | bus1.b_out;
   assign bus1.not_in = ~bus1.a_out;
   assign bus3.and_in = bus3.a_out & bus3.b_out;
   assign bus3.or_in  = bus3.a_out | bus3.b_out;
   assign bus3.not_in = ~bus3.a_out;

   gate_mux_tester #(.SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1),
      .pass(p1), .err_mask(e1), .and_tbl(at1), .or_tbl(ot1), .not_tbl(nt1), .run_cnt(rc1)
   );

   gate_mux_tester #(.SETTLE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3),
      .pass(p3), .err_mask(e3), .and_tbl(at3), .or_tbl(ot3), .not_tbl(nt3), .run_cnt(rc3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse start on dut1 and return the edge count (start edge = 0) at which done is seen; -1 on timeout.
   task automatic run1(output int edges);
      edges = -1;
      @(negedge clk);
      bus1.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus1.start = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus1.done) begin
            edges = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus1.busy, bus1.done, bus1.a_out, bus1.b_out, p1, e1} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl1: got %b expected 0", {bus1.busy, bus1.done, bus1.a_out, bus1.b_out, p1, e1});
      end
      checks++;
      if ({at1, ot1, nt1, rc1} !== 20'b0) begin
         errors++;
         $display("FAIL reset_tbl1: got %h expected 0", {at1, ot1, nt1, rc1});
      end
      checks++;
      if ({bus3.busy, bus3.done, p3, e3, at3, ot3, nt3, rc3} !== 26'b0) begin
         errors++;
         $display("FAIL reset_dut3: got %h expected 0", {bus3.busy, bus3.done, p3, e3, at3, ot3, nt3, rc3});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int edges;
      run1(edges);
      checks++;
      if (edges !== 5) begin
         errors++;
         $display("FAIL basic_latency: got %0d expected 5", edges);
      end
      checks++;
      if ({at1, ot1, nt1} !== 12'b1000_1110_0011) begin
         errors++;
         $display("FAIL basic_tables: got %b_%b_%b expected 1000_1110_0011", at1, ot1, nt1);
      end
      checks++;
      if ({p1, e1, rc1} !== {1'b1, 3'b000, 8'd1}) begin
         errors++;
         $display("FAIL basic_result: got pass=%b err=%b cnt=%0d expected 1 000 1", p1, e1, rc1);
      end
      checks++;
      if (bus1.busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy_in_done: got %b expected 0", bus1.busy);
      end
      @(negedge clk);
      checks++;
      if (bus1.done !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_width: got %b expected 0", bus1.done);
      end
   endtask

   task automatic test_abort();
      int seen_done;
      seen_done = 0;
      @(negedge clk);
      bus1.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus1.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus1.a_out, bus1.b_out} !== 2'b10) begin
         errors++;
         $display("FAIL abort_idx2_stim: got %b expected 10", {bus1.a_out, bus1.b_out});
      end
      bus1.abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus1.abort = 1'b0;
      checks++;
      if ({bus1.busy, bus1.done, bus1.a_out, bus1.b_out} !== 4'b0000) begin
         errors++;
         $display("FAIL abort_idle: got %b expected 0000", {bus1.busy, bus1.done, bus1.a_out, bus1.b_out});
      end
      checks++;
      if ({p1, e1, rc1} !== {1'b1, 3'b000, 8'd1}) begin
         errors++;
         $display("FAIL abort_hold: got pass=%b err=%b cnt=%0d expected 1 000 1", p1, e1, rc1);
      end
      checks++;
      if ({at1, ot1, nt1} !== 12'b0000_0010_0011) begin
         errors++;
         $display("FAIL abort_partial: got %b_%b_%b expected 0000_0010_0011", at1, ot1, nt1);
      end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus1.done || bus1.busy) seen_done = 1;
      end
      checks++;
      if (seen_done !== 0) begin
         errors++;
         $display("FAIL abort_no_done: got activity %0d expected 0", seen_done);
      end
   endtask

   task automatic test_stuck_and();
      int edges;
      stuck_and = 1'b1;
      run1(edges);
      stuck_and = 1'b0;
      checks++;
      if (edges !== 5) begin
         errors++;
         $display("FAIL stuck_latency: got %0d expected 5", edges);
      end
      checks++;
      if (at1 !== 4'b1111) begin
         errors++;
         $display("FAIL stuck_and_tbl: got %b expected 1111", at1);
      end
      checks++;
      if ({p1, e1, rc1} !== {1'b0, 3'b001, 8'd1}) begin
         errors++;
         $display("FAIL stuck_result: got pass=%b err=%b cnt=%0d expected 0 001 1", p1, e1, rc1);
      end
   endtask

   task automatic test_abort_vs_start();
      @(negedge clk);
      bus1.start = 1'b1;
      bus1.abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus1.start = 1'b0;
      bus1.abort = 1'b0;
      checks++;
      if (bus1.busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_beats_start: got busy=%b expected 0", bus1.busy);
      end
   endtask

   task automatic test_back_to_back();
      int edges;
      run1(edges);
      checks++;
      if ({edges, p1, e1, rc1} !== {32'sd5, 1'b1, 3'b000, 8'd2}) begin
         errors++;
         $display("FAIL b2b_run: got edges=%0d pass=%b err=%b cnt=%0d expected 5 1 000 2", edges, p1, e1, rc1);
      end
      bus1.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus1.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus1.busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_start_in_done: got busy=%b expected 0", bus1.busy);
      end
   endtask

   task automatic test_settle3();
      int         edges;
      int         seq_err;
      int         late_busy;
      logic [1:0] exp_ab;
      edges = -1;
      seq_err = 0;
      late_busy = 0;
      @(negedge clk);
      bus3.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus3.start = 1'b0;
      for (int k = 0; k <= 40; k++) begin
         if (k < 12) begin
            exp_ab = 2'(k / 3);
            if ({bus3.a_out, bus3.b_out} !== exp_ab || bus3.busy !== 1'b1) seq_err++;
         end
         if (k == 12 && bus3.busy !== 1'b1) seq_err++;
         if (k == 5) bus3.start = 1'b1;
         if (k == 6) bus3.start = 1'b0;
         if (bus3.done) begin
            edges = k;
            break;
         end
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (seq_err !== 0) begin
         errors++;
         $display("FAIL settle3_sequence: got %0d bad cycles expected 0", seq_err);
      end
      checks++;
      if (edges !== 13) begin
         errors++;
         $display("FAIL settle3_latency: got %0d expected 13", edges);
      end
      checks++;
      if ({p3, e3, rc3, at3, ot3, nt3} !== {1'b1, 3'b000, 8'd1, 12'b1000_1110_0011}) begin
         errors++;
         $display("FAIL settle3_result: got pass=%b err=%b cnt=%0d tbl=%b_%b_%b", p3, e3, rc3, at3, ot3, nt3);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus3.busy) late_busy++;
      end
      checks++;
      if (late_busy !== 0) begin
         errors++;
         $display("FAIL settle3_no_queue: got %0d busy cycles expected 0", late_busy);
      end
   endtask

   task automatic test_saturate();
      int edges;
      int bad;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         run1(edges);
         if (edges != 5) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL saturate_runs: got %0d bad runs expected 0", bad);
      end
      checks++;
      if (rc1 !== 8'd255 || p1 !== 1'b1) begin
         errors++;
         $display("FAIL saturate_cnt: got cnt=%0d pass=%b expected 255 1", rc1, p1);
      end
   endtask

   task automatic test_reset_midrun();
      @(negedge clk);
      bus1.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus1.start = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus1.busy, bus1.done, bus1.a_out, bus1.b_out, p1, e1, at1, ot1, nt1, rc1} !== 29'b0) begin
         errors++;
         $display("FAIL reset_async: got %h expected 0",
                  {bus1.busy, bus1.done, bus1.a_out, bus1.b_out, p1, e1, at1, ot1, nt1, rc1});
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus1.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus1.start = 1'b0;
      checks++;
      if (bus1.busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_start: got busy=%b expected 1", bus1.busy);
      end
      repeat (8) @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      stuck_and = 1'b0;
      rst_n = 1'b0;
      bus1.start = 1'b0;
      bus1.abort = 1'b0;
      bus3.start = 1'b0;
      bus3.abort = 1'b0;
      test_reset();
      test_basic();
      test_abort();
      test_stuck_and();
      test_abort_vs_start();
      test_back_to_back();
      test_settle3();
      test_saturate();
      test_reset_midrun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/gate_mux_tester.md
GATE_MUX_TESTER -- requirements
Module: gate_mux_tester

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning clock cycles each input combination is held before sampling; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request one test run; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1 bit: synchronous cancel of a run in progress.
REQ-006 SHALL have ports a_out and b_out, output, 1 bit each: stimulus driven to the gate block's a and b inputs.
REQ-007 SHALL have ports and_in, or_in and not_in, input, 1 bit each: responses from the gate block's and_out, or_out and not_out.
REQ-008 SHALL have port busy, output, 1 bit: high in DRIVE and CHECK.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse at run completion.
REQ-010 SHALL have port pass, output, 1 bit: result of the last completed run.
REQ-011 SHALL have port err_mask, output, 3 bits: bit0 = AND mismatch, bit1 = OR mismatch, bit2 = NOT mismatch.
REQ-012 SHALL have ports and_tbl, or_tbl and not_tbl, output, 4 bits each: captured truth tables, bit k = response for {a,b} = k.
REQ-013 SHALL have port run_cnt, output, 8 bits: count of passing runs, saturating.

Function
REQ-014 SHALL use FSM states IDLE, DRIVE, CHECK and DONE.
REQ-015 IDLE: start=1 SHALL go to DRIVE with idx=0 and settle_cnt=0; tables SHALL be cleared to 0 at that edge.
REQ-016 DRIVE: a_out=idx[1] and b_out=idx[0] (registered); settle_cnt SHALL increment each cycle.
REQ-017 DRIVE, settle_cnt==SETTLE-1: the next edge SHALL capture and_in, or_in and not_in into bit idx of the respective table, then:
- if idx==3, go to CHECK;
- otherwise idx+1 and settle_cnt=0.
REQ-018 CHECK (exactly one cycle): the exit edge SHALL register:
- err_mask = {not_tbl!=4'b0011, or_tbl!=4'b1110, and_tbl!=4'b1000};
- pass = (err_mask==0);
- run_cnt+1 if pass and run_cnt<255.
It SHALL then go to DONE.
REQ-019 DONE: done=1 for exactly one cycle, then IDLE; done SHALL be 0 in every other state.
REQ-020 Latency: done SHALL be high in the cycle following edge 4*SETTLE+1, counting the edge that samples start as edge 0.
REQ-021 start while busy or in DONE SHALL be ignored, with no queuing.
REQ-022 abort=1 in DRIVE or CHECK SHALL return to IDLE at the next edge, with no done pulse; pass, err_mask and run_cnt SHALL be unchanged, and the partial tables SHALL be retained.
REQ-023 abort and start together in IDLE: abort SHALL win and the run SHALL not start.
REQ-024 a_out and b_out SHALL be 0 in IDLE and DONE.
REQ-025 pass, err_mask, tables and run_cnt SHALL hold their values between runs.
REQ-026 SETTLE==0 SHALL be rejected at elaboration.

Reset
REQ-027 rst_n low SHALL immediately set:
- state to IDLE;
- idx, settle_cnt, a_out, b_out, busy, done, pass, err_mask, all tables and run_cnt to 0.
This SHALL apply at any time, including mid-run.
REQ-028 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-029 SETTLE=1, correct gate block, start pulse -> done 5 edges later; and_tbl=1000, or_tbl=1110, not_tbl=0011; pass=1; err_mask=000; run_cnt=1.
REQ-030 and_in stuck at 1 -> and_tbl=1111, err_mask=001, pass=0, run_cnt unchanged.
REQ-031 SETTLE=3 -> a_out/b_out step 00,01,10,11 every 3 cycles; done at edge 13; start pulsed mid-run ignored.
REQ-032 abort during idx=2 -> IDLE next cycle, no done, prior pass/err_mask held; rst_n low mid-run -> all outputs 0 asynchronously.
REQ-033 300 passing runs -> run_cnt saturates at 255.
